// File: rtl/ac3_quant_accumulator.sv
// Multi-channel AC3 stage: sums n_ops partial-sum beats per channel, then
// rounds, shifts, optionally ReLUs and saturates each channel to Pa bits.
module ac3_quant_accumulator #(
  parameter  int M     = 16,
  parameter  int Pa    = 8,
  parameter  int Pw    = 8,
  parameter  int MNO   = 288,
  parameter  int NCH   = 4,
  localparam int ACC_W = $clog2(M) + Pa + Pw + $clog2(MNO),
  localparam int CW    = $clog2(MNO + 1),
  localparam int SW    = $clog2(ACC_W)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CW-1:0]        n_ops,
  input  logic [SW-1:0]        shift,
  input  logic                 relu_en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*ACC_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*Pa-1:0]    out_data,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  // Handshakes: a beat moves on a rising edge where in_valid & in_ready;
  // the result moves on a rising edge where out_valid & out_ready.

  typedef enum logic [1:0] {IDLE, ACC, QUANT, OUT} state_t;

  // Headroom so the rounding add and large shifts never overflow.
  localparam int QW = ACC_W + 4;
  localparam logic signed [QW-1:0] SAT_HI = QW'(2 ** (Pa - 1) - 1);
  localparam logic signed [QW-1:0] SAT_LO = -SAT_HI - QW'(1);

  state_t           state;
  logic [ACC_W-1:0] acc [NCH];
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    n_ops_q;
  logic [SW-1:0]    shift_q;
  logic             relu_q;
  logic [NCH*Pa-1:0] q_data;

  assign dbg_state = state;

  always_comb begin
    logic signed [QW-1:0] r;
    q_data = '0;
    r      = '0;
    for (int c = 0; c < NCH; c++) begin
      r = QW'(signed'(acc[c]));
      if (shift_q != '0) r = r + (QW'(1) <<< (shift_q - SW'(1)));
      r = r >>> shift_q;
      if (relu_q && (r < 0)) r = '0;
      if (r > SAT_HI) r = SAT_HI;
      if (r < SAT_LO) r = SAT_LO;
      q_data[c*Pa +: Pa] = r[Pa-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      for (int c = 0; c < NCH; c++) acc[c] <= '0;
      cnt       <= '0;
      n_ops_q   <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int c = 0; c < NCH; c++) acc[c] <= '0;
            cnt     <= '0;
            n_ops_q <= n_ops;
            shift_q <= shift;
            relu_q  <= relu_en;
            busy    <= 1'b1;
            if (n_ops != '0) begin
              state    <= ACC;
              in_ready <= 1'b1;
            end else begin
              state <= QUANT;
            end
          end
        end
        ACC: begin
          if (in_valid && in_ready) begin
            for (int c = 0; c < NCH; c++)
              acc[c] <= acc[c] + in_data[c*ACC_W +: ACC_W];
            cnt <= cnt + CW'(1);
            if (cnt + CW'(1) == n_ops_q) begin
              state    <= QUANT;
              in_ready <= 1'b0;
            end
          end
        end
        QUANT: begin
          out_data  <= q_data;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ac3_quant_accumulator.sv
// Bench for ac3_quant_accumulator: directed and random jobs checked against
// an arithmetic model of the accumulate/round/shift/ReLU/saturate rules.
module tb_ac3_quant_accumulator;
  localparam int NCH   = 4;
  localparam int Pa    = 8;
  localparam int ACC_W = 29;
  localparam int CW    = 9;
  localparam int SW    = 5;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [CW-1:0]        n_ops;
  logic [SW-1:0]        shift;
  logic                 relu_en;
  logic                 in_valid;
  logic                 in_ready;
  logic [NCH*ACC_W-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [NCH*Pa-1:0]    out_data;
  logic                 busy;
  logic [1:0]           dbg_state;

  ac3_quant_accumulator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_ops(n_ops), .shift(shift),
    .relu_en(relu_en), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [NCH*Pa-1:0]    exp_q[$];
  logic [NCH*ACC_W-1:0] beats_q[$];
  int                   gaps_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic [Pa-1:0] model_q(input longint sum, input int sh, input bit relu);
    longint r;
    r = (sum <<< (64 - ACC_W)) >>> (64 - ACC_W);
    if (sh > 0) r = r + (longint'(1) <<< (sh - 1));
    r = r >>> sh;
    if (relu && r < 0) r = 0;
    if (r > 2 ** (Pa - 1) - 1) r = 2 ** (Pa - 1) - 1;
    if (r < -(2 ** (Pa - 1))) r = -(2 ** (Pa - 1));
    return r[Pa-1:0];
  endfunction

  function automatic logic [NCH*ACC_W-1:0] mk(input int c0, input int c1, input int c2, input int c3);
    int v[NCH];
    logic [NCH*ACC_W-1:0] b;
    v[0] = c0; v[1] = c1; v[2] = c2; v[3] = c3;
    b = '0;
    for (int c = 0; c < NCH; c++) b[c*ACC_W +: ACC_W] = v[c][ACC_W-1:0];
    return b;
  endfunction

  // ---------------- driver ----------------
  task automatic run_job(input int n, input int sh, input bit relu,
                         input int rdy_delay, input bit poke_start);
    longint sums[NCH];
    logic [NCH*Pa-1:0] exp;
    logic signed [ACC_W-1:0] v;
    int g;
    for (int c = 0; c < NCH; c++) sums[c] = 0;
    foreach (beats_q[i])
      for (int c = 0; c < NCH; c++) begin
        v = beats_q[i][c*ACC_W +: ACC_W];
        sums[c] += v;
      end
    exp = '0;
    for (int c = 0; c < NCH; c++) exp[c*Pa +: Pa] = model_q(sums[c], sh, relu);
    exp_q.push_back(exp);

    @(negedge clk);
    start = 1'b1; n_ops = CW'(n); shift = SW'(sh); relu_en = relu;
    @(negedge clk);
    start = 1'b0;
    n_ops = CW'($urandom()); shift = SW'($urandom()); relu_en = 1'($urandom());
    chk("busy_after_start", busy, 1);
    chk("in_ready_after_start", in_ready, (n != 0));
    while (beats_q.size() > 0) begin
      g = (gaps_q.size() > 0) ? gaps_q.pop_front() : 0;
      repeat (g) begin
        in_valid = 1'b0;
        in_data  = (NCH*ACC_W)'({$urandom(), $urandom(), $urandom(), $urandom()});
        @(negedge clk);
        chk("in_ready_gap", in_ready, 1);
      end
      in_data  = beats_q.pop_front();
      in_valid = 1'b1;
      chk("in_ready_beat", in_ready, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    // One edge after the last beat (or the start for n=0): QUANT cycle.
    chk("quant_out_valid", out_valid, 0);
    chk("quant_in_ready", in_ready, 0);
    @(negedge clk);
    chk("latency_out_valid", out_valid, 1);
    for (int d = 0; d < rdy_delay; d++) begin
      out_ready = 1'b0;
      if (poke_start && d == 1) begin start = 1'b1; n_ops = CW'(5); end
      @(negedge clk);
      start = 1'b0;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_busy", busy, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_out_valid", out_valid, 0);
    chk("post_hs_busy", busy, 0);
    chk("post_hs_in_ready", in_ready, 0);
  endtask

  // ---------------- scoreboard / compare ----------------
  logic [NCH*Pa-1:0] last_data;
  bit                pend;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      last_data = '0;
      pend      = 1'b0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out_valid: got out_data %0h with no job pending", out_data);
      end else begin
        chk("out_data", out_data, exp_q[0]);
      end
      if (pend) chk("out_stable", out_data, last_data);
      last_data = out_data;
      if (out_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        pend = 1'b0;
      end else begin
        pend = 1'b1;
      end
    end else begin
      chk("out_hold", out_data, last_data);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, sh, c0, c1, c2, c3;
    rst_n = 1'b0; start = 1'b0; n_ops = '0; shift = '0; relu_en = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    chk("model_round_11", model_q(11, 2, 0), 8'h03);
    chk("model_round_m6", model_q(-6, 2, 0), 8'hFF);
    chk("model_round_m7", model_q(-7, 2, 0), 8'hFE);
    chk("model_sat_hi", model_q(1000, 0, 0), 8'h7F);
    chk("model_relu", model_q(-1000, 0, 1), 8'h00);

    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;

    // Basic accumulate with an idle cycle between beats 1 and 2.
    beats_q = '{mk(10, 0, 0, 0), mk(20, 0, 0, 0), mk(30, 0, 0, 0)};
    gaps_q  = '{0, 1, 0};
    run_job(3, 0, 0, 0, 0);
    chk("basic_lit", out_data, 32'h0000003C);

    beats_q = '{mk(11, -6, -7, 2)};
    run_job(1, 2, 0, 1, 0);
    chk("round_lit", out_data, 32'h01FEFF03);

    beats_q = '{mk(600, -600, 0, 0), mk(400, -400, 0, 0)};
    run_job(2, 0, 0, 0, 0);
    chk("sat_lit", out_data, 32'h0000807F);
    beats_q = '{mk(600, -600, 0, 0), mk(400, -400, 0, 0)};
    run_job(2, 0, 1, 0, 0);
    chk("relu_lit", out_data, 32'h0000007F);

    // Reset mid-ACC: no partial sum may survive.
    @(negedge clk);
    start = 1'b1; n_ops = CW'(3); shift = '0; relu_en = 1'b0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = mk(10, 10, 10, 10);
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_data", out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_busy", busy, 0);
    beats_q = '{mk(5, 0, 0, 0)};
    run_job(1, 0, 0, 0, 0);
    chk("postrst_lit", out_data, 32'h00000005);

    // Backpressure with a start pulse during OUT.
    beats_q = '{mk(100, -3, 7, 1), mk(-20, 50, 9, 126)};
    gaps_q  = '{0, 2};
    run_job(2, 1, 0, 5, 1);

    // Zero operands.
    run_job(0, 3, 0, 0, 0);
    chk("zero_ops_lit", out_data, 32'h00000000);

    for (int j = 0; j < 30; j++) begin
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) begin
        c0 = $urandom_range(0, 1) ? int'($urandom_range(0, 600)) - 300 : int'($urandom());
        c1 = $urandom_range(0, 1) ? int'($urandom_range(0, 600)) - 300 : int'($urandom());
        c2 = $urandom_range(0, 1) ? int'($urandom_range(0, 600)) - 300 : int'($urandom());
        c3 = $urandom_range(0, 1) ? int'($urandom_range(0, 600)) - 300 : int'($urandom());
        beats_q.push_back(mk(c0, c1, c2, c3));
        gaps_q.push_back(int'($urandom_range(0, 2)));
      end
      sh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6));
      run_job(n, sh, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
      gaps_q.delete();
    end

    repeat (3) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
